// File: rtl/tilelink_uncached_sram_manager_if.sv
// Uncached TileLink acquire/grant channel pair between a client (master) and a manager (slave).
interface tilelink_uncached_sram_manager_if;
  logic        acquire_ready;
  logic        acquire_valid;
  logic [25:0] acquire_bits_addr_block;
  logic        acquire_bits_client_xact_id;
  logic [2:0]  acquire_bits_addr_beat;
  logic        acquire_bits_is_builtin_type;
  logic [2:0]  acquire_bits_a_type;
  logic [11:0] acquire_bits_union;
  logic [63:0] acquire_bits_data;

  logic        grant_ready;
  logic        grant_valid;
  logic [2:0]  grant_bits_addr_beat;
  logic        grant_bits_client_xact_id;
  logic [1:0]  grant_bits_manager_xact_id;
  logic        grant_bits_is_builtin_type;
  logic [3:0]  grant_bits_g_type;
  logic [63:0] grant_bits_data;

  modport master (
    input  acquire_ready,
    output acquire_valid, acquire_bits_addr_block, acquire_bits_client_xact_id,
    output acquire_bits_addr_beat, acquire_bits_is_builtin_type, acquire_bits_a_type,
    output acquire_bits_union, acquire_bits_data,
    output grant_ready,
    input  grant_valid, grant_bits_addr_beat, grant_bits_client_xact_id,
    input  grant_bits_manager_xact_id, grant_bits_is_builtin_type, grant_bits_g_type,
    input  grant_bits_data
  );

  modport slave (
    output acquire_ready,
    input  acquire_valid, acquire_bits_addr_block, acquire_bits_client_xact_id,
    input  acquire_bits_addr_beat, acquire_bits_is_builtin_type, acquire_bits_a_type,
    input  acquire_bits_union, acquire_bits_data,
    input  grant_ready,
    output grant_valid, grant_bits_addr_beat, grant_bits_client_xact_id,
    output grant_bits_manager_xact_id, grant_bits_is_builtin_type, grant_bits_g_type,
    output grant_bits_data
  );
endinterface

// File: rtl/tilelink_uncached_sram_manager.sv
// Uncached TileLink manager terminating acquire/grant onto a 64-bit byte-maskable scratchpad.
// One transaction outstanding at a time; block transfers move 8 beats in order.
module tilelink_uncached_sram_manager #(
  parameter int unsigned DEPTH_WORDS     = 512,
  parameter int unsigned MANAGER_XACT_ID = 0
) (
  input logic                           clk,
  input logic                           reset,
  tilelink_uncached_sram_manager_if.slave io
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] AGet      = 3'd0;
  localparam logic [2:0] AGetBlock = 3'd1;
  localparam logic [2:0] APut      = 3'd2;
  localparam logic [2:0] APutBlock = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StGetResp,
    StGetBlkResp,
    StPutBlkData,
    StPutAck
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [25:0] blk_q;
  logic        id_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic             acq_fire;
  logic             gnt_fire;
  logic             wr_en;
  logic [25:0]      wr_blk;
  logic [2:0]       wr_beat;
  logic [7:0]       wr_mask;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_union;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign io.acquire_ready = reset && (state_q == StIdle || state_q == StPutBlkData);
  assign io.grant_valid   = (state_q == StGetResp) || (state_q == StGetBlkResp) ||
                            (state_q == StPutAck);
  assign acq_fire = io.acquire_valid && io.acquire_ready;
  assign gnt_fire = io.grant_valid && io.grant_ready;

  assign wr_mask      = io.acquire_bits_union[8:1];
  assign unused_union = ^{io.acquire_bits_union[11:9], io.acquire_bits_union[0]};

  always_comb begin
    wr_en   = 1'b0;
    wr_blk  = io.acquire_bits_addr_block;
    wr_beat = io.acquire_bits_addr_beat;
    if (state_q == StIdle) begin
      wr_en = acq_fire && io.acquire_bits_is_builtin_type &&
              (io.acquire_bits_a_type == APut || io.acquire_bits_a_type == APutBlock);
      if (io.acquire_bits_a_type == APutBlock) wr_beat = 3'd0;
    end else if (state_q == StPutBlkData) begin
      wr_en   = acq_fire;
      wr_blk  = blk_q;
      wr_beat = cnt_q;
    end
  end

  // Addresses beyond the array alias by dropping the high bits.
  assign wr_idx = IDX_W'({wr_blk, wr_beat});
  assign rd_idx = IDX_W'({blk_q, cnt_q});

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (wr_en && wr_mask[b]) mem[wr_idx][8*b +: 8] <= io.acquire_bits_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      blk_q   <= 26'd0;
      id_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (acq_fire) begin
            id_q  <= io.acquire_bits_client_xact_id;
            blk_q <= io.acquire_bits_addr_block;
            if (!io.acquire_bits_is_builtin_type) begin
              state_q <= StPutAck;
            end else begin
              case (io.acquire_bits_a_type)
                AGet: begin
                  cnt_q   <= io.acquire_bits_addr_beat;
                  state_q <= StGetResp;
                end
                AGetBlock: begin
                  cnt_q   <= 3'd0;
                  state_q <= StGetBlkResp;
                end
                APutBlock: begin
                  cnt_q   <= 3'd1;
                  state_q <= StPutBlkData;
                end
                default: state_q <= StPutAck;
              endcase
            end
          end
        end
        StGetResp: begin
          if (gnt_fire) begin
            cnt_q   <= 3'd0;
            state_q <= StIdle;
          end
        end
        StGetBlkResp: begin
          if (gnt_fire) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= StIdle;
          end
        end
        StPutBlkData: begin
          if (acq_fire) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= StPutAck;
          end
        end
        StPutAck: begin
          if (gnt_fire) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    io.grant_bits_g_type    = 4'd3;
    io.grant_bits_addr_beat = 3'd0;
    io.grant_bits_data      = 64'd0;
    if (state_q == StGetResp || state_q == StGetBlkResp) begin
      io.grant_bits_g_type    = (state_q == StGetResp) ? 4'd4 : 4'd5;
      io.grant_bits_addr_beat = cnt_q;
      io.grant_bits_data      = mem[rd_idx];
    end
  end

  assign io.grant_bits_client_xact_id  = id_q;
  assign io.grant_bits_manager_xact_id = 2'(MANAGER_XACT_ID);
  assign io.grant_bits_is_builtin_type = 1'b1;

endmodule

// File: doc/tilelink_uncached_sram_manager.md
Name: tilelink_uncached_sram_manager

Overview:
- Manager-side endpoint of the uncached TileLink client port: accepts Acquire messages and returns Grant messages.
- Backs a small on-chip 64-bit-wide scratchpad.
- Sits at the out side of the client uncached arbiter, terminating its acquire/grant channels.
- Used as the memory target for boot/scratch space and as a self-contained verification target for client-side blocks.

Parameters:
DEPTH_WORDS, 512, number of 64-bit words; power of two, minimum 8; IDX_W = log2(DEPTH_WORDS).
MANAGER_XACT_ID, 0, constant driven on io_grant_bits_manager_xact_id.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
io_acquire_ready  out  1  manager can take an acquire beat.
io_acquire_valid  in  1  acquire beat valid.
io_acquire_bits_addr_block  in  26  block address (8 beats x 8 bytes per block).
io_acquire_bits_client_xact_id  in  1  client transaction id.
io_acquire_bits_addr_beat  in  3  beat within block.
io_acquire_bits_is_builtin_type  in  1  must be 1; builtin types only.
io_acquire_bits_a_type  in  3  0=Get, 1=GetBlock, 2=Put, 3=PutBlock, others unsupported.
io_acquire_bits_union  in  12  for Put/PutBlock, byte write mask = union[8:1]; ignored for gets.
io_acquire_bits_data  in  64  write data.
io_grant_ready  in  1  client accepts grant beat.
io_grant_valid  out  1  grant beat valid.
io_grant_bits_addr_beat  out  3  beat index of returned data.
io_grant_bits_client_xact_id  out  1  echo of the captured client_xact_id.
io_grant_bits_manager_xact_id  out  2  MANAGER_XACT_ID.
io_grant_bits_is_builtin_type  out  1  constant 1.
io_grant_bits_g_type  out  4  3=PutAck, 4=GetDataBeat, 5=GetDataBlock.
io_grant_bits_data  out  64  read data; 0 for PutAck.

Behaviour:
- Word index = {addr_block, beat} truncated to the low IDX_W bits. Out-of-range addresses alias; no error is reported.
- Reset (reset low, asynchronous):
  - state = IDLE, beat counter = 0, captured id = 0.
  - io_grant_valid = 0, io_acquire_ready = 0 while reset is asserted, then 1 in IDLE.
  - Array contents are not reset.
  - Reset mid-transaction aborts the transaction with no grant issued; partial PutBlock writes already done remain.
- FSM states: IDLE, GET_RESP, GETBLK_RESP, PUTBLK_DATA, PUT_ACK.
- IDLE: io_acquire_ready = 1, io_grant_valid = 0. On acquire fire (valid & ready), capture client_xact_id, then:
  - Get: capture addr_beat → GET_RESP.
  - GetBlock: counter = 0 → GETBLK_RESP.
  - Put: write mem[{addr_block, addr_beat}] with data under mask, same edge (bytes with mask bit 0 unchanged) → PUT_ACK.
  - PutBlock: write beat 0 at {addr_block, 0} under mask, capture addr_block, counter = 1 → PUTBLK_DATA.
  - Unsupported a_type or is_builtin_type = 0: no array access → PUT_ACK.
- GET_RESP:
  - acquire_ready = 0; grant_valid = 1; g_type = 4; addr_beat = captured beat; data = combinational read of the array.
  - Grant fire → IDLE.
- GETBLK_RESP:
  - acquire_ready = 0; grant_valid = 1; g_type = 5; addr_beat = counter; data = mem[{block, counter}].
  - Grant fire with counter = 7 → counter = 0, IDLE; otherwise counter++.
  - Beats go out back-to-back when grant_ready stays high: 8 grant cycles, beats 0..7.
- PUTBLK_DATA:
  - acquire_ready = 1; grant_valid = 0.
  - Each acquire fire writes mem[{captured block, counter}] under mask. Incoming addr_beat and a_type are ignored; beats are strictly in order.
  - Fire with counter = 7 → counter = 0, PUT_ACK; otherwise counter++.
- PUT_ACK:
  - acquire_ready = 0; grant_valid = 1; g_type = 3; addr_beat = 0; data = 0.
  - Grant fire → IDLE.
- Grant bits hold stable while grant_valid = 1 and grant_ready = 0; state does not advance.
- No acquire is accepted during GET_RESP, GETBLK_RESP or PUT_ACK, so only one transaction is outstanding at a time.
- Minimum latency from acquire fire to grant_valid is 1 cycle.
- Back-to-back: a grant fire returning to IDLE allows an acquire fire on the next cycle; there is no same-cycle accept.

Test Plan:
- Reset low for 3 cycles mid-GetBlock (beat 3) → grant_valid = 0 immediately, acquire_ready = 1 on the first cycle after release, state IDLE.
- Put block=0x10 beat=2 data=0x1122334455667788 mask=0xFF id=1, then Get same address → PutAck (g_type 3, id 1, beat 0, data 0), then GetDataBeat data 0x1122334455667788, beat 2, id 1.
- Put mask=0x0F data=0xFFFFFFFFFFFFFFFF over word 0x1122334455667788, then Get → 0x11223344FFFFFFFF.
- PutBlock block=0x3 data=beat*0x0101010101010101 for beats 0..7 with acquire_valid toggling, then GetBlock with grant_ready low on alternate cycles → 8 beats, addr_beat 0..7, data matching, bits stable while stalled, exactly one PutAck after beat 7.
- Unsupported a_type = 4 → single PutAck, array unchanged (verify with a follow-up Get), acquire_ready low until the ack fires.
- DEPTH_WORDS = 512: Put at block 0x40 beat 0 aliases to index 0 → Get block 0 beat 0 returns the same data.
